// File: rtl/mq_pkg.sv
// Shared constants for the MQ arithmetic coder: probability-state tables,
// interval initial value and the initial context assignment.
package mq_pkg;

    localparam int          NUM_CX  = 19;
    localparam int          NUM_ST  = 47;
    localparam logic [15:0] A_INIT  = 16'h8000;

    typedef struct packed {
        logic [5:0] idx;
        logic       mps;
    } cx_entry_t;

    localparam logic [15:0] QE_TAB [0:NUM_ST-1] = '{
        16'h5601, 16'h3401, 16'h1801, 16'h0AC1, 16'h0521, 16'h0221, 16'h5601, 16'h5401,
        16'h4801, 16'h3801, 16'h3001, 16'h2401, 16'h1C01, 16'h1601, 16'h5601, 16'h5401,
        16'h5101, 16'h4801, 16'h3801, 16'h3401, 16'h3001, 16'h2801, 16'h2401, 16'h2201,
        16'h1C01, 16'h1801, 16'h1601, 16'h1401, 16'h1201, 16'h1101, 16'h0AC1, 16'h09C1,
        16'h08A1, 16'h0521, 16'h0441, 16'h02A1, 16'h0221, 16'h0141, 16'h0111, 16'h0085,
        16'h0049, 16'h0025, 16'h0015, 16'h0009, 16'h0005, 16'h0001, 16'h5601
    };

    localparam logic [5:0] NMPS_TAB [0:NUM_ST-1] = '{
        6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd38, 6'd7,  6'd8,
        6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd29, 6'd15, 6'd16,
        6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24,
        6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32,
        6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd40,
        6'd41, 6'd42, 6'd43, 6'd44, 6'd45, 6'd45, 6'd46
    };

    localparam logic [5:0] NLPS_TAB [0:NUM_ST-1] = '{
        6'd1,  6'd6,  6'd9,  6'd12, 6'd29, 6'd33, 6'd6,  6'd14,
        6'd14, 6'd14, 6'd17, 6'd18, 6'd20, 6'd21, 6'd14, 6'd14,
        6'd15, 6'd16, 6'd17, 6'd18, 6'd19, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
        6'd38, 6'd39, 6'd40, 6'd41, 6'd42, 6'd43, 6'd46
    };

    localparam logic SWITCH_TAB [0:NUM_ST-1] = '{
        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0
    };

    // Uniform context 18, run-length context 17 and zero-coding context 0
    // start in non-zero states; every other context starts at state 0.
    localparam cx_entry_t CX_INIT [0:NUM_CX-1] = '{
        '{idx: 6'd4,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0},
        '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0},
        '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0},
        '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0},
        '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0},
        '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd0,  mps: 1'b0}, '{idx: 6'd3,  mps: 1'b0},
        '{idx: 6'd46, mps: 1'b0}
    };

endpackage

// File: rtl/mq_qe_rom.sv
// Combinational probability-state lookup: state index -> Qe and transitions.
module mq_qe_rom
    import mq_pkg::*;
(
    input  logic [5:0]  idx_in,
    output logic [15:0] qe_out,
    output logic [5:0]  nmps_out,
    output logic [5:0]  nlps_out,
    output logic        switch_out
);

    logic [5:0] idx_c;

    always_comb begin
        // Indices 47..63 never occur; fold them onto the terminal state.
        idx_c      = (idx_in < 6'(NUM_ST)) ? idx_in : 6'd46;
        qe_out     = QE_TAB[idx_c];
        nmps_out   = NMPS_TAB[idx_c];
        nlps_out   = NLPS_TAB[idx_c];
        switch_out = SWITCH_TAB[idx_c];
    end

endmodule

// File: rtl/mq_interval_update.sv
// MQ coder interval/probability update: codes one symbol per cycle, updating
// the context table and interval A, and emits registered renormalisation data.
module mq_interval_update
    import mq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  cx_in,
    input  logic        d_in,
    input  logic        valid_in,
    input  logic        flush_in,
    input  logic        init_in,
    output logic        valid_out,
    output logic [15:0] qe_out,
    output logic        add_qe_out,
    output logic [3:0]  shift_out,
    output logic [15:0] a_out,
    output logic        flush_out,
    output logic        cx_err
);

    cx_entry_t   cx_q [0:NUM_CX-1];
    cx_entry_t   cx_d [0:NUM_CX-1];
    logic [15:0] a_q, a_d;
    logic        valid_out_q, valid_out_d;
    logic [15:0] qe_out_q, qe_out_d;
    logic        add_qe_out_q, add_qe_out_d;
    logic [3:0]  shift_out_q, shift_out_d;
    logic [15:0] a_out_q, a_out_d;
    logic        flush_out_q, flush_out_d;
    logic        cx_err_q, cx_err_d;

    logic        cx_legal;
    logic [4:0]  cx_sel;
    logic        sym_go;
    cx_entry_t   entry;
    cx_entry_t   entry_upd;
    logic [15:0] rom_qe;
    logic [5:0]  rom_nmps;
    logic [5:0]  rom_nlps;
    logic        rom_switch;
    logic [15:0] at;
    logic [15:0] a_new;
    logic        add_qe;
    logic        renorm;
    logic [3:0]  shift_c;
    logic [15:0] a_ren;

    // Position of the most significant set bit, expressed as a left-shift count.
    function automatic logic [3:0] lzc16(input logic [15:0] v);
        logic [3:0] n;
        n = 4'd15;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) n = 4'(15 - i);
        end
        return n;
    endfunction

    assign cx_legal = (cx_in < 5'(NUM_CX));
    assign cx_sel   = cx_legal ? cx_in : 5'd0;
    assign sym_go   = valid_in && cx_legal && !init_in;
    assign entry    = cx_q[cx_sel];

    mq_qe_rom u_rom (
        .idx_in     (entry.idx),
        .qe_out     (rom_qe),
        .nmps_out   (rom_nmps),
        .nlps_out   (rom_nlps),
        .switch_out (rom_switch)
    );

    always_comb begin
        at        = a_q - rom_qe;
        a_new     = at;
        add_qe    = 1'b1;
        renorm    = 1'b0;
        entry_upd = entry;
        if (d_in == entry.mps) begin
            if (!at[15]) begin
                renorm        = 1'b1;
                entry_upd.idx = rom_nmps;
                if (at < rom_qe) begin
                    a_new  = rom_qe;
                    add_qe = 1'b0;
                end
            end
        end else begin
            renorm        = 1'b1;
            entry_upd.idx = rom_nlps;
            entry_upd.mps = entry.mps ^ rom_switch;
            if (!(at < rom_qe)) begin
                a_new  = rom_qe;
                add_qe = 1'b0;
            end
        end
        shift_c = renorm ? lzc16(a_new) : 4'd0;
        a_ren   = a_new << shift_c;
    end

    always_comb begin
        cx_d         = cx_q;
        a_d          = a_q;
        qe_out_d     = qe_out_q;
        add_qe_out_d = add_qe_out_q;
        shift_out_d  = shift_out_q;
        a_out_d      = a_out_q;
        valid_out_d  = sym_go;
        flush_out_d  = flush_in && !init_in;
        cx_err_d     = cx_err_q | (valid_in && !cx_legal);

        if (sym_go) begin
            qe_out_d     = rom_qe;
            add_qe_out_d = add_qe;
            shift_out_d  = shift_c;
            a_out_d      = a_ren;
            a_d          = a_ren;
            cx_d[cx_sel] = entry_upd;
        end
        // A flushed codeword restarts its interval after the last symbol.
        if (flush_in) begin
            a_d = A_INIT;
        end
        if (init_in) begin
            a_d     = A_INIT;
            a_out_d = A_INIT;
            cx_d    = CX_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q         <= CX_INIT;
            a_q          <= A_INIT;
            valid_out_q  <= 1'b0;
            qe_out_q     <= 16'h0000;
            add_qe_out_q <= 1'b0;
            shift_out_q  <= 4'd0;
            a_out_q      <= A_INIT;
            flush_out_q  <= 1'b0;
            cx_err_q     <= 1'b0;
        end else begin
            cx_q         <= cx_d;
            a_q          <= a_d;
            valid_out_q  <= valid_out_d;
            qe_out_q     <= qe_out_d;
            add_qe_out_q <= add_qe_out_d;
            shift_out_q  <= shift_out_d;
            a_out_q      <= a_out_d;
            flush_out_q  <= flush_out_d;
            cx_err_q     <= cx_err_d;
        end
    end

    assign valid_out  = valid_out_q;
    assign qe_out     = qe_out_q;
    assign add_qe_out = add_qe_out_q;
    assign shift_out  = shift_out_q;
    assign a_out      = a_out_q;
    assign flush_out  = flush_out_q;
    assign cx_err     = cx_err_q;

endmodule

// File: tb/tb_mq_interval_update.sv
// Directed bench for mq_interval_update with hand-computed MQ coder results.
module tb_mq_interval_update;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  cx_in;
    logic        d_in;
    logic        valid_in;
    logic        flush_in;
    logic        init_in;
    logic        valid_out;
    logic [15:0] qe_out;
    logic        add_qe_out;
    logic [3:0]  shift_out;
    logic [15:0] a_out;
    logic        flush_out;
    logic        cx_err;

    int n_chk  = 0;
    int n_fail = 0;

    mq_interval_update dut (
        .clk        (clk),
        .rst        (rst),
        .cx_in      (cx_in),
        .d_in       (d_in),
        .valid_in   (valid_in),
        .flush_in   (flush_in),
        .init_in    (init_in),
        .valid_out  (valid_out),
        .qe_out     (qe_out),
        .add_qe_out (add_qe_out),
        .shift_out  (shift_out),
        .a_out      (a_out),
        .flush_out  (flush_out),
        .cx_err     (cx_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic [4:0] cx, input logic d,
                       input logic v, input logic fl, input logic in);
        rst      = r;
        cx_in    = cx;
        d_in     = d;
        valid_in = v;
        flush_in = fl;
        init_in  = in;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_sym(input string tag, input logic [15:0] qe, input logic add,
                           input logic [3:0] sh, input logic [15:0] a, input logic fl);
        chk({tag, "_valid"}, 32'(valid_out), 32'd1);
        chk({tag, "_qe"},    32'(qe_out),    32'(qe));
        chk({tag, "_add"},   32'(add_qe_out), 32'(add));
        chk({tag, "_shift"}, 32'(shift_out), 32'(sh));
        chk({tag, "_a"},     32'(a_out),     32'(a));
        chk({tag, "_flush"}, 32'(flush_out), 32'(fl));
    endtask

    task automatic do_reset();
        cyc(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_qe",    32'(qe_out),    32'd0);
        chk("rst_add",   32'(add_qe_out), 32'd0);
        chk("rst_shift", 32'(shift_out), 32'd0);
        chk("rst_a",     32'(a_out),     32'h8000);
        chk("rst_flush", 32'(flush_out), 32'd0);
        chk("rst_err",   32'(cx_err),    32'd0);

        // cx0 from state 4: MPS with At<0x8000, renormalise by one
        cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("cx0_a", 16'h0521, 1'b1, 4'd1, 16'hF5BE, 1'b0);
        // cx0 now state 5; At keeps bit 15, no renormalisation
        cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("cx0_b", 16'h0221, 1'b1, 4'd0, 16'hF39D, 1'b0);

        // cx18: conditional exchange, state stays 46
        do_reset();
        cyc(1'b0, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("cx18_a", 16'h5601, 1'b0, 4'd1, 16'hAC02, 1'b0);
        cyc(1'b0, 5'd18, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("cx18_b", 16'h5601, 1'b1, 4'd1, 16'hAC02, 1'b0);

        // LPS with MPS switch, then back-to-back MPS on the updated context
        do_reset();
        cyc(1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_sym("lps_sw", 16'h5601, 1'b1, 4'd2, 16'hA7FC, 1'b0);
        cyc(1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_sym("b2b", 16'h3401, 1'b1, 4'd1, 16'hE7F6, 1'b0);
        cyc(1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("mps_hi", 16'h5601, 1'b1, 4'd0, 16'h91F5, 1'b0);

        // Idle: no valid, qe/add/shift hold
        cyc(1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_valid", 32'(valid_out), 32'd0);
        chk("idle_qe",    32'(qe_out),    32'h5601);
        chk("idle_add",   32'(add_qe_out), 32'd1);
        chk("idle_shift", 32'(shift_out), 32'd0);

        // Symbol coded together with flush, then A restarts at 0x8000
        cyc(1'b0, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_sym("flush_sym", 16'h5601, 1'b0, 4'd1, 16'hAC02, 1'b1);
        cyc(1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("after_flush", 16'h5601, 1'b0, 4'd1, 16'hAC02, 1'b0);
        cyc(1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("cx2_st1", 16'h3401, 1'b1, 4'd1, 16'hF002, 1'b0);

        // Illegal context: dropped, sticky error, A untouched
        cyc(1'b0, 5'd20, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bad_valid", 32'(valid_out), 32'd0);
        chk("bad_err",   32'(cx_err),    32'd1);
        cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bad_err_hold", 32'(cx_err), 32'd1);
        cyc(1'b0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("after_bad", 16'h5601, 1'b1, 4'd0, 16'h9A01, 1'b0);

        // init overrides flush and discards the coincident symbol
        cyc(1'b0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("init_valid", 32'(valid_out), 32'd0);
        chk("init_flush", 32'(flush_out), 32'd0);
        chk("init_a",     32'(a_out),     32'h8000);
        chk("init_err",   32'(cx_err),    32'd1);
        cyc(1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("init_cx2", 16'h5601, 1'b0, 4'd1, 16'hAC02, 1'b0);

        // LPS with At>=Qe: exchange, switch MPS, then MPS on new sense
        cyc(1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_sym("lps_exch", 16'h5601, 1'b0, 4'd1, 16'hAC02, 1'b0);
        cyc(1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_sym("mps_new", 16'h3401, 1'b1, 4'd1, 16'hF002, 1'b0);

        // Mid-stream reset wins over a coincident symbol
        cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mid_rst_valid", 32'(valid_out), 32'd0);
        chk("mid_rst_err",   32'(cx_err),    32'd0);
        chk("mid_rst_a",     32'(a_out),     32'h8000);
        chk("mid_rst_flush", 32'(flush_out), 32'd0);
        cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_sym("post_rst", 16'h0521, 1'b1, 4'd1, 16'hF5BE, 1'b0);

        cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mq_interval_update.md
MQ_INTERVAL_UPDATE -- requirements
Module: mq_interval_update

Interface
REQ-001 SHALL have: clk  in  1  clock, rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: cx_in  in  5  context label from the input-register stage, legal 0..18.
REQ-004 SHALL have: d_in  in  1  decision bit.
REQ-005 SHALL have: valid_in  in  1  cx_in/d_in hold a symbol this cycle.
REQ-006 SHALL have: flush_in  in  1  end-of-codeword request.
REQ-007 SHALL have: init_in  in  1  re-initialise context table and A at code-block start.
REQ-008 SHALL have: valid_out  out  1  outputs hold one coded symbol.
REQ-009 SHALL have: qe_out  out  16  Qe used for the symbol.
REQ-010 SHALL have: add_qe_out  out  1  downstream C register adds qe_out.
REQ-011 SHALL have: shift_out  out  4  renormalisation left-shift count, 0..15.
REQ-012 SHALL have: a_out  out  16  interval register after renormalisation.
REQ-013 SHALL have: flush_out  out  1  flush request forwarded downstream.
REQ-014 SHALL have: cx_err  out  1  sticky, illegal context seen.

Function
REQ-015 SHALL keep 19 context entries {I[5:0], MPS}, held in flops, read combinationally.
REQ-016 SHALL produce all outputs exactly 1 cycle after the accepted input, registered; no back-pressure.
REQ-017 Per valid symbol: Qe=QE[I(cx)]; At=A-Qe (16-bit, no wrap, as At>=0 always holds).
REQ-018 MPS (d_in==MPS): if At[15]=1, A=At, add_qe=1, shift=0, context unchanged.
REQ-019 MPS with At[15]=0: if At<Qe then A=Qe, add_qe=0, else A=At, add_qe=1; I=NMPS[I]; renormalise.
REQ-020 LPS: if At<Qe then A=At, add_qe=1, else A=Qe, add_qe=0; if SWITCH[I] invert MPS; I=NLPS[I]; renormalise.
REQ-021 Renormalise: shift=leading zeros of A, A<<=shift, so a_out[15]=1 whenever valid_out=1.
REQ-022 Back-to-back symbols on the same context SHALL use the updated entry with no stall.
REQ-023 valid_in=0: A, table unchanged; valid_out=0; qe/add/shift outputs hold previous values.
REQ-024 cx_in>18 with valid_in: treated as not valid (no update, valid_out=0), cx_err set until rst.
REQ-025 flush_in: flush_out=1 next cycle; if valid_in same cycle, symbol is coded first and flush_out accompanies its outputs; A then becomes 0x8000.
REQ-026 init_in: next cycle A=0x8000 and context table at initial values; coincident valid_in symbol is discarded; init_in overrides flush_in.

Reset
REQ-027 rst SHALL set A=0x8000, contexts initial (cx0 I=4, cx17 I=3, cx18 I=46, others I=0; all MPS=0).
REQ-028 rst SHALL clear valid_out, add_qe_out, flush_out, cx_err and zero qe_out, shift_out; a_out=0x8000.
REQ-029 rst SHALL take priority over every other input, including mid-stream.

Structure
REQ-030 Shared package mq_pkg SHALL hold the 47-entry QE/NMPS/NLPS/SWITCH tables, A_INIT=0x8000, NUM_CX=19, initial context values.
REQ-031 Sub-module mq_qe_rom SHALL map index[5:0] to {qe, nmps, nlps, switch}, combinational.

Verification
REQ-032 After rst, cx=0 d=0 -> qe=0x0521, add_qe=1, shift=1, a_out=0xF5BE; cx0 I becomes 5.
REQ-033 After rst, cx=18 d=0 -> qe=0x5601, add_qe=0, shift=1, a_out=0xAC02; I stays 46.
REQ-034 After rst, cx=1 d=1 -> add_qe=1, shift=2, a_out=0xA7FC, MPS(1)=1, I=1; next cycle cx=1 d=1 -> qe=0x3401, add_qe=1, shift=1, a_out=0xE7F6.
REQ-035 Then cx=2 d=0 -> qe=0x5601, At=0x91F5, add_qe=1, shift=0, a_out=0x91F5.
REQ-036 valid+flush together -> symbol outputs with flush_out=1 same cycle, next symbol starts from A=0x8000; cx_in=20 -> no valid_out, cx_err=1 until rst.
REQ-037 rst asserted mid-stream, then cx=0 d=0 -> identical response to REQ-032.
